gci_bus_router: RTL

Sits directly downstream of the peripheral interface controller on the GCI side. Takes its single request stream (req/busy/rw/addr/data), decodes the address to one of four device ports, forwards writes and reads, and returns read data through the return channel. It also arbitrates the four device interrupt lines into the single IRQ request/number/ack channel the controller consumes.

---
 rtl/gci_router_pkg.sv | 49 ++++
 rtl/gci_irq_arbiter.sv | 72 +++++++
 rtl/gci_bus_router.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gci_router_pkg.sv
// gci_router_pkg: shared types, widths and helpers for the GCI bus router.
// Holds the device count, read/IRQ state encodings, the device-index type,
// the forwarded request payload and the fixed-priority select function.
package gci_router_pkg;

    localparam int unsigned GCI_DEV_NUM   = 4;
    localparam int unsigned GCI_DEV_W     = 2;
    localparam int unsigned GCI_DATA_W    = 32;
    localparam int unsigned GCI_ADDR_W    = 32;
    localparam int unsigned GCI_IRQ_NUM_W = 6;

    typedef logic [GCI_DEV_W-1:0] dev_idx_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RET  = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_PEND = 2'd1,
        I_ACK  = 2'd2
    } irq_state_t;

    // Request held in the forward slot and presented to the devices
    typedef struct packed {
        logic                  rw;
        logic [GCI_ADDR_W-1:0] addr;
        logic [GCI_DATA_W-1:0] data;
        dev_idx_t              dev;
    } gci_req_t;

    // Lowest set bit wins (device 0 highest priority)
    function automatic dev_idx_t prio_first(input logic [GCI_DEV_NUM-1:0] req);
        dev_idx_t idx;
        logic     found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(GCI_DEV_NUM); i++) begin
            if (req[i] && !found) begin
                idx   = dev_idx_t'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gci_irq_arbiter.sv
// gci_irq_arbiter: merges the device interrupt lines into one IRQ channel.
// Ports: iCLOCK/iRESET(async)/iRESET_SYNC; iDEV_IRQ_REQ/iDEV_IRQ_NUM device
// requests and numbers; oDEV_IRQ_ACK one-cycle ack to the winner;
// oEXTIO_IRQ_REQ/oEXTIO_IRQ_NUM/iEXTIO_IRQ_ACK upstream interrupt handshake.
module gci_irq_arbiter
    import gci_router_pkg::*;
(
    input  logic                                 iCLOCK,
    input  logic                                 iRESET,
    input  logic                                 iRESET_SYNC,
    input  logic [GCI_DEV_NUM-1:0]               iDEV_IRQ_REQ,
    input  logic [GCI_DEV_NUM*GCI_IRQ_NUM_W-1:0] iDEV_IRQ_NUM,
    output logic [GCI_DEV_NUM-1:0]               oDEV_IRQ_ACK,
    output logic                                 oEXTIO_IRQ_REQ,
    output logic [GCI_IRQ_NUM_W-1:0]             oEXTIO_IRQ_NUM,
    input  logic                                 iEXTIO_IRQ_ACK
);

    irq_state_t               state, state_nxt;
    dev_idx_t                 winner, winner_nxt;
    logic [GCI_IRQ_NUM_W-1:0] num, num_nxt;

    // State register; winner and number stay latched until re-arbitration
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state  <= I_IDLE;
            winner <= '0;
            num    <= '0;
        end else if (iRESET_SYNC) begin
            state  <= I_IDLE;
            winner <= '0;
            num    <= '0;
        end else begin
            state  <= state_nxt;
            winner <= winner_nxt;
            num    <= num_nxt;
        end
    end

    // Arbitration only from I_IDLE, so a dropped request cannot change the winner
    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        num_nxt    = num;
        case (state)
            I_IDLE: begin
                if (|iDEV_IRQ_REQ) begin
                    winner_nxt = prio_first(iDEV_IRQ_REQ);
                    num_nxt    = iDEV_IRQ_NUM[winner_nxt*GCI_IRQ_NUM_W +: GCI_IRQ_NUM_W];
                    state_nxt  = I_PEND;
                end
            end
            I_PEND: begin
                if (iEXTIO_IRQ_ACK) begin
                    state_nxt = I_ACK;
                end
            end
            I_ACK:   state_nxt = I_IDLE;
            default: state_nxt = I_IDLE;
        endcase
    end

    // Ack pulse to the latched winner
    always_comb begin
        oDEV_IRQ_ACK         = '0;
        oDEV_IRQ_ACK[winner] = (state == I_ACK);
    end

    assign oEXTIO_IRQ_REQ = (state == I_PEND);
    assign oEXTIO_IRQ_NUM = num;

endmodule

// File: rtl/gci_bus_router.sv
// gci_bus_router: decodes the GCI request stream onto four device ports,
// returns read data upstream and arbitrates device interrupts.
// Ports: iCLOCK, iRESET (async), iRESET_SYNC; upstream request
// iEXTIO_REQ/RW/ADDR/DATA with oEXTIO_BUSY; read return oEXTIO_REQ/DATA with
// iEXTIO_BUSY; IRQ oEXTIO_IRQ_REQ/NUM with iEXTIO_IRQ_ACK; device request
// oDEV_REQ/RW/ADDR/DATA with iDEV_BUSY; device return iDEV_VALID/DATA with
// oDEV_BUSY; device IRQ iDEV_IRQ_REQ/NUM with oDEV_IRQ_ACK.
module gci_bus_router
    import gci_router_pkg::*;
#(
    parameter int unsigned           P_SEL_LSB    = 24,
    parameter logic [GCI_DATA_W-1:0] P_UNMAP_DATA = 32'hFFFF_FFFF
) (
    input  logic                                 iCLOCK,
    input  logic                                 iRESET,
    input  logic                                 iRESET_SYNC,
    input  logic                                 iEXTIO_REQ,
    output logic                                 oEXTIO_BUSY,
    input  logic                                 iEXTIO_RW,
    input  logic [GCI_ADDR_W-1:0]                iEXTIO_ADDR,
    input  logic [GCI_DATA_W-1:0]                iEXTIO_DATA,
    output logic                                 oEXTIO_REQ,
    input  logic                                 iEXTIO_BUSY,
    output logic [GCI_DATA_W-1:0]                oEXTIO_DATA,
    output logic                                 oEXTIO_IRQ_REQ,
    output logic [GCI_IRQ_NUM_W-1:0]             oEXTIO_IRQ_NUM,
    input  logic                                 iEXTIO_IRQ_ACK,
    output logic [GCI_DEV_NUM-1:0]               oDEV_REQ,
    input  logic [GCI_DEV_NUM-1:0]               iDEV_BUSY,
    output logic                                 oDEV_RW,
    output logic [GCI_ADDR_W-1:0]                oDEV_ADDR,
    output logic [GCI_DATA_W-1:0]                oDEV_DATA,
    input  logic [GCI_DEV_NUM-1:0]               iDEV_VALID,
    input  logic [GCI_DEV_NUM*GCI_DATA_W-1:0]    iDEV_DATA,
    output logic                                 oDEV_BUSY,
    input  logic [GCI_DEV_NUM-1:0]               iDEV_IRQ_REQ,
    input  logic [GCI_DEV_NUM*GCI_IRQ_NUM_W-1:0] iDEV_IRQ_NUM,
    output logic [GCI_DEV_NUM-1:0]               oDEV_IRQ_ACK
);

    gci_req_t              slot;
    logic                  slot_valid;
    rd_state_t             rd_state, rd_state_nxt;
    dev_idx_t              rd_dev, rd_dev_nxt;
    logic [GCI_DATA_W-1:0] rd_buf, rd_buf_nxt;

    logic     mapped;
    dev_idx_t sel_dev;
    logic     rd_pending;
    logic     accept;
    logic     slot_drain;

    // Address decode: upper bits above the select field must be zero
    assign mapped  = ((iEXTIO_ADDR >> (P_SEL_LSB + 2)) == '0);
    assign sel_dev = dev_idx_t'(iEXTIO_ADDR >> P_SEL_LSB);

    assign rd_pending  = (rd_state != R_IDLE);
    assign oEXTIO_BUSY = (slot_valid && iDEV_BUSY[slot.dev]) || rd_pending;
    assign accept      = iEXTIO_REQ && !oEXTIO_BUSY;
    assign slot_drain  = slot_valid && !iDEV_BUSY[slot.dev];

    // Forward slot: an accept while the slot drains reloads it in the same cycle
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            slot_valid <= 1'b0;
            slot       <= '0;
        end else if (iRESET_SYNC) begin
            slot_valid <= 1'b0;
            slot       <= '0;
        end else if (accept && mapped) begin
            slot_valid <= 1'b1;
            slot       <= '{rw: iEXTIO_RW, addr: iEXTIO_ADDR, data: iEXTIO_DATA, dev: sel_dev};
        end else if (slot_drain) begin
            slot_valid <= 1'b0;
        end
    end

    always_comb begin
        oDEV_REQ           = '0;
        oDEV_REQ[slot.dev] = slot_valid;
    end

    assign oDEV_RW   = slot.rw;
    assign oDEV_ADDR = slot.addr;
    assign oDEV_DATA = slot.data;

    // Read tracker state register
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            rd_state <= R_IDLE;
            rd_dev   <= '0;
            rd_buf   <= '0;
        end else if (iRESET_SYNC) begin
            rd_state <= R_IDLE;
            rd_dev   <= '0;
            rd_buf   <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            rd_dev   <= rd_dev_nxt;
            rd_buf   <= rd_buf_nxt;
        end
    end

    // Read tracker next state; only the target device's valid counts in R_WAIT
    always_comb begin
        rd_state_nxt = rd_state;
        rd_dev_nxt   = rd_dev;
        rd_buf_nxt   = rd_buf;
        case (rd_state)
            R_IDLE: begin
                if (accept && !iEXTIO_RW) begin
                    rd_dev_nxt = sel_dev;
                    if (mapped) begin
                        rd_state_nxt = R_WAIT;
                    end else begin
                        rd_buf_nxt   = P_UNMAP_DATA;
                        rd_state_nxt = R_RET;
                    end
                end
            end
            R_WAIT: begin
                if (iDEV_VALID[rd_dev]) begin
                    rd_buf_nxt   = iDEV_DATA[rd_dev*GCI_DATA_W +: GCI_DATA_W];
                    rd_state_nxt = R_RET;
                end
            end
            R_RET: begin
                if (!iEXTIO_BUSY) begin
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign oEXTIO_REQ  = (rd_state == R_RET);
    assign oEXTIO_DATA = rd_buf;
    assign oDEV_BUSY   = (rd_state == R_RET);

    gci_irq_arbiter u_irq (
        .iCLOCK         (iCLOCK),
        .iRESET         (iRESET),
        .iRESET_SYNC    (iRESET_SYNC),
        .iDEV_IRQ_REQ   (iDEV_IRQ_REQ),
        .iDEV_IRQ_NUM   (iDEV_IRQ_NUM),
        .oDEV_IRQ_ACK   (oDEV_IRQ_ACK),
        .oEXTIO_IRQ_REQ (oEXTIO_IRQ_REQ),
        .oEXTIO_IRQ_NUM (oEXTIO_IRQ_NUM),
        .iEXTIO_IRQ_ACK (iEXTIO_IRQ_ACK)
    );

endmodule
